// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame buffer clear, geometry kick, drain detection and frame counting.
// Optional render watchdog is enabled by defining FRAME_SEQ_TIMEOUT_EN.
module frame_sequencer #(
    parameter int               FB_WORDS       = 76800,
    parameter int               ADDR_W         = 17,
    parameter int               PIX_W          = 12,
    parameter int               Z_W            = 8,
    parameter logic [PIX_W-1:0] CLEAR_COLOR    = '0,
    parameter logic [Z_W-1:0]   CLEAR_DEPTH    = '1,
    parameter int               IDLE_HOLD      = 16,
    parameter int               TIMEOUT_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_frame_done,
    output logic [3:0]        o_frame_idx,
    output logic              o_geom_start,
    input  logic              i_geom_busy,
    input  logic              i_rast_busy,
    input  logic              i_rast_fifo_empty,
    input  logic              i_tri_valid,
    input  logic [ADDR_W-1:0] i_rast_fb_addr,
    input  logic              i_rast_fb_we,
    input  logic [PIX_W-1:0]  i_rast_fb_pixel,
    input  logic [ADDR_W-1:0] i_rast_zb_addr,
    input  logic              i_rast_zb_we,
    input  logic [Z_W-1:0]    i_rast_zb_data,
    output logic [ADDR_W-1:0] o_fb_addr,
    output logic              o_fb_we,
    output logic [PIX_W-1:0]  o_fb_pixel,
    output logic [ADDR_W-1:0] o_zb_addr,
    output logic              o_zb_we,
    output logic [Z_W-1:0]    o_zb_data,
    output logic              o_timeout
);
    typedef enum logic [2:0] {IDLE, CLEAR, KICK, RENDER, DONE} state_t;
    localparam int IW = $clog2(IDLE_HOLD + 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_WORDS - 1);
    state_t state, state_nx;
    logic [ADDR_W-1:0] clr_cnt;
    logic [IW-1:0] idle_cnt;
    logic [3:0] frame_idx;
    logic idle, hold_hit, wd_hit, clr, rnd;
    assign idle = !i_geom_busy && !i_rast_busy && i_rast_fifo_empty && !i_tri_valid;
    assign hold_hit = idle && idle_cnt == IW'(IDLE_HOLD - 1);
    assign clr = state == CLEAR;
    assign rnd = state == RENDER;
`ifdef FRAME_SEQ_TIMEOUT_EN
    logic [19:0] rnd_cnt;
    logic timeout;
    assign wd_hit = rnd && rnd_cnt == 20'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rnd_cnt <= '0;
            timeout <= 1'b0;
        end else begin
            rnd_cnt <= rnd ? rnd_cnt + 20'd1 : '0;
            timeout <= timeout | wd_hit;
        end
    end
    assign o_timeout = timeout;
`else
    assign wd_hit = 1'b0;
    assign o_timeout = 1'b0;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            clr_cnt <= '0;
            idle_cnt <= '0;
            frame_idx <= '0;
        end else begin
            state <= state_nx;
            clr_cnt <= (clr && clr_cnt != LAST) ? clr_cnt + 1'b1 : '0;
            idle_cnt <= (rnd && idle) ? idle_cnt + 1'b1 : '0;
            frame_idx <= (state == DONE) ? frame_idx + 4'd1 : frame_idx;
        end
    end
    // Write ports: clear engine in CLEAR, rasterizer pass-through in RENDER, closed otherwise.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = i_start ? CLEAR : IDLE;
            CLEAR:   state_nx = (clr_cnt == LAST) ? KICK : CLEAR;
            KICK:    state_nx = RENDER;
            RENDER:  state_nx = (hold_hit || wd_hit) ? DONE : RENDER;
            default: state_nx = IDLE;
        endcase
        o_busy = state != IDLE;
        o_frame_done = state == DONE;
        o_geom_start = state == KICK;
        o_frame_idx = frame_idx;
        o_fb_we = clr || (rnd && i_rast_fb_we);
        o_zb_we = clr || (rnd && i_rast_zb_we);
        o_fb_addr = clr ? clr_cnt : rnd ? i_rast_fb_addr : '0;
        o_zb_addr = clr ? clr_cnt : rnd ? i_rast_zb_addr : '0;
        o_fb_pixel = clr ? CLEAR_COLOR : rnd ? i_rast_fb_pixel : '0;
        o_zb_data = clr ? CLEAR_DEPTH : rnd ? i_rast_zb_data : '0;
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: randomized frame scenes checked against a timeline model of the sequencer.
module tb_frame_sequencer;
    localparam int FB = 16, IH = 16, TO = 100, AW = 17, PW = 12, ZW = 8;
    logic clk = 0, rst = 1, i_start = 0;
    logic o_busy, o_frame_done, o_geom_start, o_fb_we, o_zb_we, o_timeout;
    logic [3:0] o_frame_idx;
    logic i_geom_busy = 0, i_rast_busy = 0, i_rast_fifo_empty = 1, i_tri_valid = 0;
    logic [AW-1:0] i_rast_fb_addr = 0, i_rast_zb_addr = 0, o_fb_addr, o_zb_addr;
    logic i_rast_fb_we = 0, i_rast_zb_we = 0;
    logic [PW-1:0] i_rast_fb_pixel = 0, o_fb_pixel;
    logic [ZW-1:0] i_rast_zb_data = 0, o_zb_data;
    int errors = 0, checks = 0, dr;
    logic [3:0] exp_idx = 0;
    logic exp_to = 0;
    bit directed = 0;
    logic [3:0] scene[$];

    frame_sequencer #(.FB_WORDS(FB), .IDLE_HOLD(IH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .i_start(i_start), .o_busy(o_busy), .o_frame_done(o_frame_done),
        .o_frame_idx(o_frame_idx), .o_geom_start(o_geom_start), .i_geom_busy(i_geom_busy),
        .i_rast_busy(i_rast_busy), .i_rast_fifo_empty(i_rast_fifo_empty), .i_tri_valid(i_tri_valid),
        .i_rast_fb_addr(i_rast_fb_addr), .i_rast_fb_we(i_rast_fb_we), .i_rast_fb_pixel(i_rast_fb_pixel),
        .i_rast_zb_addr(i_rast_zb_addr), .i_rast_zb_we(i_rast_zb_we), .i_rast_zb_data(i_rast_zb_data),
        .o_fb_addr(o_fb_addr), .o_fb_we(o_fb_we), .o_fb_pixel(o_fb_pixel), .o_zb_addr(o_zb_addr),
        .o_zb_we(o_zb_we), .o_zb_data(o_zb_data), .o_timeout(o_timeout));

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drive_writes;
        if (directed) begin
            i_rast_fb_we = 1; i_rast_fb_addr = 5; i_rast_fb_pixel = 12'hF0A;
            i_rast_zb_we = 1; i_rast_zb_addr = 5; i_rast_zb_data = 8'h20;
        end else begin
            i_rast_fb_we = 1'($urandom); i_rast_fb_addr = AW'($urandom); i_rast_fb_pixel = PW'($urandom);
            i_rast_zb_we = 1'($urandom); i_rast_zb_addr = AW'($urandom); i_rast_zb_data = ZW'($urandom);
        end
    endtask

    // One full frame: clear sweep, kick, render against the scene queue, done, back to idle.
    // Model: done follows the first render cycle preceded by IH all-idle render cycles.
    task automatic run_frame(output int done_r);
        logic [3:0] code;
        bit hist[$];
        bit nxt;
        i_start = 1;
        step();
        for (int k = 0; k < FB; k++) begin
            drive_writes();
            i_start = 1'($urandom);
            #1;
            checks++;
            if ({o_busy, o_fb_we, o_zb_we, o_geom_start, o_frame_done} !== 5'b11100 || o_fb_addr !== AW'(k)
                || o_zb_addr !== AW'(k) || o_fb_pixel !== 12'h000 || o_zb_data !== 8'hFF) begin
                errors++;
                $display("FAIL clear[%0d]: got we=%b/%b addr=%0d/%0d pix=%h z=%h, want we=1/1 addr=%0d pix=000 z=ff",
                         k, o_fb_we, o_zb_we, o_fb_addr, o_zb_addr, o_fb_pixel, o_zb_data, k);
            end
            step();
        end
        drive_writes();
        #1;
        checks++;
        if ({o_busy, o_fb_we, o_zb_we, o_geom_start, o_frame_done} !== 5'b10010) begin
            errors++;
            $display("FAIL kick: got busy/fbwe/zbwe/gs/done=%b want 10010",
                     {o_busy, o_fb_we, o_zb_we, o_geom_start, o_frame_done});
        end
        step();
        done_r = -1;
        for (int r = 0; r < 400 && done_r < 0; r++) begin
            code = (scene.size() > r) ? scene[r] : 4'h0;
            {i_geom_busy, i_rast_busy} = code[3:2];
            i_rast_fifo_empty = !code[1];
            i_tri_valid = code[0];
            drive_writes();
            i_start = 1'($urandom);
            #1;
            checks++;
            if ({o_fb_we, o_fb_addr, o_fb_pixel, o_zb_we, o_zb_addr, o_zb_data} !==
                {i_rast_fb_we, i_rast_fb_addr, i_rast_fb_pixel, i_rast_zb_we, i_rast_zb_addr, i_rast_zb_data}
                || {o_busy, o_geom_start, o_frame_done} !== 3'b100 || o_timeout !== exp_to) begin
                errors++;
                $display("FAIL render[%0d]: got fb=%b/%0d/%h zb=%b/%0d/%h busy/gs/done=%b to=%b, want fb=%b/%0d/%h zb=%b/%0d/%h 100 to=%b",
                         r, o_fb_we, o_fb_addr, o_fb_pixel, o_zb_we, o_zb_addr, o_zb_data,
                         {o_busy, o_geom_start, o_frame_done}, o_timeout, i_rast_fb_we, i_rast_fb_addr,
                         i_rast_fb_pixel, i_rast_zb_we, i_rast_zb_addr, i_rast_zb_data, exp_to);
            end
            hist.push_back(code == 4'h0);
            nxt = r + 1 >= IH;
            for (int j = r + 1 - IH; nxt && j <= r; j++) if (!hist[j]) nxt = 0;
`ifdef FRAME_SEQ_TIMEOUT_EN
            if (r + 1 == TO) begin
                nxt = 1;
                exp_to = 1;
            end
`endif
            step();
            if (nxt) done_r = r + 1;
        end
        i_start = 0;
        {i_geom_busy, i_rast_busy, i_rast_fifo_empty, i_tri_valid} = 4'b0010;
        drive_writes();
        #1;
        checks++;
        if (done_r < 0 || {o_busy, o_frame_done, o_fb_we, o_zb_we, o_geom_start} !== 5'b11000
            || o_frame_idx !== exp_idx || o_timeout !== exp_to) begin
            errors++;
            $display("FAIL done: got busy/done/fbwe/zbwe/gs=%b idx=%0d to=%b, want 11000 idx=%0d to=%b (render cycles %0d)",
                     {o_busy, o_frame_done, o_fb_we, o_zb_we, o_geom_start}, o_frame_idx, o_timeout,
                     exp_idx, exp_to, done_r);
        end
        step();
        exp_idx++;
        #1;
        checks++;
        if ({o_busy, o_frame_done, o_fb_we, o_zb_we} !== 4'b0000 || o_frame_idx !== exp_idx) begin
            errors++;
            $display("FAIL idle: got busy/done/fbwe/zbwe=%b idx=%0d, want 0000 idx=%0d",
                     {o_busy, o_frame_done, o_fb_we, o_zb_we}, o_frame_idx, exp_idx);
        end
    endtask

    task automatic test_reset;
        i_start = 1;
        #3;
        checks++;
        if ({o_busy, o_frame_done, o_geom_start, o_fb_we, o_zb_we, o_timeout, o_frame_idx,
             o_fb_addr, o_zb_addr, o_fb_pixel, o_zb_data} !== '0) begin
            errors++;
            $display("FAIL reset: got busy=%b we=%b/%b idx=%0d to=%b, want all zero",
                     o_busy, o_fb_we, o_zb_we, o_frame_idx, o_timeout);
        end
        i_start = 0;
        rst = 0;
        step();
    endtask

    task automatic test_empty_frame;
        scene = {};
        run_frame(dr);
        checks++;
        if (dr !== IH) begin
            errors++;
            $display("FAIL empty_latency: got %0d render cycles, want %0d", dr, IH);
        end
    endtask

    task automatic test_passthrough_glitch;
        scene = {};
        repeat (40) scene.push_back(4'b0100);
        repeat (8) scene.push_back(4'b0000);
        scene.push_back(4'b0001);
        directed = 1;
        run_frame(dr);
        directed = 0;
        checks++;
        if (dr !== 49 + IH) begin
            errors++;
            $display("FAIL glitch_latency: got %0d render cycles, want %0d", dr, 49 + IH);
        end
    endtask

    task automatic test_random_frames;
        for (int f = 0; f < 5; f++) begin
            scene = {};
            repeat ($urandom_range(0, 60)) scene.push_back(4'($urandom));
            run_frame(dr);
        end
    endtask

    task automatic test_reset_mid_clear;
        i_start = 1;
        step();
        i_start = 0;
        repeat (7) step();
        #1;
        checks++;
        if (o_fb_addr !== AW'(7) || o_fb_we !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_addr: got we=%b addr=%0d, want we=1 addr=7", o_fb_we, o_fb_addr);
        end
        rst = 1;
        #1;
        checks++;
        if ({o_busy, o_frame_done, o_geom_start, o_fb_we, o_zb_we, o_timeout, o_frame_idx,
             o_fb_addr, o_zb_addr, o_fb_pixel, o_zb_data} !== '0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b we=%b/%b addr=%0d idx=%0d to=%b, want all zero",
                     o_busy, o_fb_we, o_zb_we, o_fb_addr, o_frame_idx, o_timeout);
        end
        rst = 0;
        exp_idx = 0;
        exp_to = 0;
        step();
        scene = {};
        run_frame(dr);
    endtask

    task automatic test_wrap;
        scene = {};
        for (int f = 0; f < 16 && exp_idx != 0; f++) run_frame(dr);
        checks++;
        if (o_frame_idx !== 4'd0) begin
            errors++;
            $display("FAIL wrap: got idx=%0d, want 0", o_frame_idx);
        end
    endtask

    task automatic test_timeout;
        scene = {};
        repeat (200) scene.push_back(4'b0100);
        run_frame(dr);
        checks++;
`ifdef FRAME_SEQ_TIMEOUT_EN
        if (dr !== TO || o_timeout !== 1'b1) begin
            errors++;
            $display("FAIL timeout: got %0d render cycles to=%b, want %0d to=1", dr, o_timeout, TO);
        end
`else
        if (dr !== 200 + IH || o_timeout !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout: got %0d render cycles to=%b, want %0d to=0", dr, o_timeout, 200 + IH);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_passthrough_glitch();
        test_random_frames();
        test_reset_mid_clear();
        test_wrap();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule

// File: doc/frame_sequencer.md
Name: frame_sequencer

Overview:
Per-frame controller placed between fpga_top's geometry/rasterizer pipeline and the frame-buffer/z-buffer write ports. On start it clears both buffers (colour CLEAR_COLOR, depth CLEAR_DEPTH), pulses the geometry engine start, then owns the buffer write ports on the rasterizer's behalf until the whole pipeline has drained. It then reports frame done and advances a frame index. It replaces the buffer clearing and idle detection that are currently done only in the testbench.

Parameters:
FB_WORDS, 76800, buffer depth in pixels (320x240)
ADDR_W, 17, buffer address width
PIX_W, 12, pixel width (4R4G4B)
Z_W, 8, depth width
CLEAR_COLOR, 12'h000, colour written during clear
CLEAR_DEPTH, 8'hFF, depth written during clear (far plane)
IDLE_HOLD, 16, consecutive idle cycles required to declare the frame drained
TIMEOUT_CYCLES, 500000, render watchdog limit (used only with the optional feature)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
i_start  in  1  frame request; sampled only in IDLE
o_busy  out  1  high in every state except IDLE
o_frame_done  out  1  one-cycle pulse when the frame completes
o_frame_idx  out  4  completed-frame counter
o_geom_start  out  1  one-cycle start pulse to the geometry engine
i_geom_busy  in  1  geometry engine active
i_rast_busy  in  1  rasterizer o_busy
i_rast_fifo_empty  in  1  rasterizer input FIFO empty
i_tri_valid  in  1  triangle assembler o_tri_valid
i_rast_fb_addr  in  ADDR_W  rasterizer frame-buffer address
i_rast_fb_we  in  1  rasterizer frame-buffer write enable
i_rast_fb_pixel  in  PIX_W  rasterizer pixel
i_rast_zb_addr  in  ADDR_W  rasterizer z-buffer write address
i_rast_zb_we  in  1  rasterizer z-buffer write enable
i_rast_zb_data  in  Z_W  rasterizer depth
o_fb_addr  out  ADDR_W  frame-buffer write address
o_fb_we  out  1  frame-buffer write enable
o_fb_pixel  out  PIX_W  frame-buffer write data
o_zb_addr  out  ADDR_W  z-buffer write address
o_zb_we  out  1  z-buffer write enable
o_zb_data  out  Z_W  z-buffer write data
o_timeout  out  1  sticky watchdog flag (with the optional feature only)

Behaviour:
- Clock and reset: single clock clk. rst is asynchronous and active-high.
- Reset: state=IDLE; clear counter=0; idle counter=0; o_frame_idx=0. o_busy, o_frame_done, o_geom_start, o_fb_we, o_zb_we and o_timeout are 0. All addr/data outputs are 0.
- State machine:
  - IDLE->CLEAR when i_start=1. i_start is ignored in every other state; no queuing.
  - CLEAR: one registered write per cycle to both buffers at the same address, counting 0..FB_WORDS-1. o_fb_we=o_zb_we=1, data=CLEAR_COLOR/CLEAR_DEPTH. The first write appears the cycle after i_start is sampled. After writing FB_WORDS-1 -> KICK. The clear takes exactly FB_WORDS cycles.
  - KICK: o_geom_start=1 for exactly one cycle; idle counter cleared -> RENDER.
  - RENDER:
    - Write ports are a combinational pass-through of the i_rast_* inputs (zero latency).
    - idle = !i_geom_busy & !i_rast_busy & i_rast_fifo_empty & !i_tri_valid.
    - idle counter increments while idle and resets to 0 on any non-idle cycle.
    - When the counter reaches IDLE_HOLD -> DONE.
  - DONE: o_frame_done=1 for one cycle; o_frame_idx increments (wraps 15->0) -> IDLE.
- Port ownership:
  - Outside RENDER, i_rast_* writes are blocked: o_fb_we/o_zb_we are driven only by the clear engine and are 0 in IDLE/KICK/DONE.
  - A rasterizer write arriving during CLEAR is dropped, not buffered.
- Startup latency: the IDLE_HOLD window covers the delay between o_geom_start and i_geom_busy rising. An empty scene therefore completes IDLE_HOLD cycles after entering RENDER.
- Reset mid-operation (any state): immediate return to IDLE with reset values. Partial clear contents are left as-is. o_frame_idx returns to 0.
- Addresses never exceed FB_WORDS-1 from the clear engine; rasterizer addresses are passed through unchecked.

Optional Feature:
FRAME_SEQ_TIMEOUT_EN
- Defined:
  - A 20-bit render cycle counter runs in RENDER.
  - On reaching TIMEOUT_CYCLES: o_timeout set (sticky until rst), state -> DONE, and o_frame_done still pulses.
- Undefined:
  - No counter is instantiated; o_timeout is tied to 0.
  - RENDER waits indefinitely for the idle condition.

Test Plan:
- FB_WORDS=16, i_start pulse -> o_fb_we/o_zb_we high 16 consecutive cycles, addr 0..15, pixel 12'h000, depth 8'hFF. Then one o_geom_start pulse.
- Empty scene (all idle inputs idle), IDLE_HOLD=16 -> o_frame_done exactly 16 cycles after the RENDER entry cycle; o_frame_idx 0->1.
- In RENDER, drive i_rast_fb_we=1, addr 5, pixel 12'hF0A and i_rast_zb_we=1, data 8'h20 -> identical values on the outputs in the same cycle. The same stimulus during CLEAR -> no write at addr 5 beyond the clear value.
- In RENDER: i_rast_busy high for 40 cycles, then low with 1-cycle i_tri_valid glitch 8 cycles later -> done only 16 cycles after the glitch ends. i_start pulses mid-frame are ignored.
- rst asserted at clear address 7 -> outputs 0 and state IDLE asynchronously. Next i_start restarts the clear from addr 0.
- FRAME_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=100, i_rast_busy held high -> o_timeout=1 and o_frame_done pulse after 100 RENDER cycles. Run 16 frames -> o_frame_idx wraps 15->0.
